user_entry: RTL and testbench

- Collects the player's 4-digit hex guess during the recall phase and presents it as `userInt` with a held `inputReady` flag. This block is the input side of the game loop; the 7-segment display block is the output side.
- Digit value comes from switches. Each digit is committed by a debounced Enter button; a debounced Clear button restarts entry.
- Output feeds the input checker (against `randInt`) and the display block (`userInput`, `inputReady`).

---
 rtl/game_pkg.sv | 18 +
 rtl/btn_debounce.sv | 70 +++++++
 rtl/user_entry.sv | 113 +++++++++++
 tb/tb_user_entry.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the memory-game entry path: entry FSM encoding and digit sizing.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2
    } entry_state_e;

    localparam int NUM_DIGITS_DEF = 4;
    localparam int DIGIT_W        = 4;

    // Index of each button inside the debouncer array.
    localparam int BTN_ENTER = 0;
    localparam int BTN_CLEAR = 1;
    localparam int NUM_BTNS  = 2;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw push-button, debounces it on sampleTick and emits a one-clk press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sampleTick,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [1:0]    sync_q;
    logic [1:0]    vld_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;
    logic          synced;

    assign synced = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            vld_q   <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            vld_q   <= {vld_q[0], 1'b1};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    // A button held through reset must be seen released once before it may produce a press.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        press_d = 1'b0;
        if (sampleTick) begin
            if (vld_q[1] && !synced) begin
                armed_d = 1'b1;
            end
            if (synced != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                    press_d = ~level_q & armed_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/user_entry.sv
// Collects a NUM_DIGITS hex guess from switches, one digit per debounced Enter press.
module user_entry
    import game_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int NUM_DIGITS     = NUM_DIGITS_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sampleTick,
    input  logic                              entryEnable,
    input  logic [DIGIT_W-1:0]                sw,
    input  logic                              btnEnter,
    input  logic                              btnClear,
    output logic [DIGIT_W*NUM_DIGITS-1:0]     userInt,
    output logic                              inputReady,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digitCount,
    output logic                              entryActive
);

    localparam int UW = DIGIT_W * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;

    assign btn_raw[BTN_ENTER] = btnEnter;
    assign btn_raw[BTN_CLEAR] = btnClear;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
            ) u_btn (
                .clk        (clk),
                .rst        (rst),
                .sampleTick (sampleTick),
                .raw        (btn_raw[gi]),
                .level      (btn_level[gi]),
                .press      (btn_press[gi])
            );
        end
    endgenerate

    entry_state_e  state_q, state_d;
    logic [UW-1:0] user_q, user_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          enter_press, clear_press;
    logic          unused_level;

    assign enter_press  = btn_press[BTN_ENTER];
    assign clear_press  = btn_press[BTN_CLEAR];
    assign unused_level = ^btn_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            user_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            user_q  <= user_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: entryEnable low beats Clear, Clear beats Enter.
    always_comb begin
        state_d = state_q;
        user_d  = user_q;
        cnt_d   = cnt_q;
        if (!entryEnable) begin
            state_d = ST_IDLE;
            user_d  = '0;
            cnt_d   = '0;
        end else if (clear_press) begin
            state_d = ST_ENTRY;
            user_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ENTRY;
                    user_d  = '0;
                    cnt_d   = '0;
                end
                ST_ENTRY: begin
                    if (enter_press) begin
                        user_d = {user_q[UW-DIGIT_W-1:0], sw};
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_q == CW'(NUM_DIGITS - 1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                    user_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign userInt     = user_q;
    assign digitCount  = cnt_q;
    assign inputReady  = (state_q == ST_DONE);
    assign entryActive = (state_q == ST_ENTRY);

endmodule

// File: tb/tb_user_entry.sv
// Randomised and directed checks of user_entry against a behavioural model of the guess-entry rules.
module tb_user_entry;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sampleTick;
    logic        entryEnable;
    logic [3:0]  sw;
    logic        btnEnter;
    logic        btnClear;
    logic [15:0] userInt;
    logic        inputReady;
    logic [2:0]  digitCount;
    logic        entryActive;

    int tests = 0;
    int fails = 0;
    bit checking = 0;
    bit rand_tick = 0;
    int tick_cnt = 0;

    user_entry #(.DEBOUNCE_TICKS(T), .NUM_DIGITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .sampleTick  (sampleTick),
        .entryEnable (entryEnable),
        .sw          (sw),
        .btnEnter    (btnEnter),
        .btnClear    (btnClear),
        .userInt     (userInt),
        .inputReady  (inputReady),
        .digitCount  (digitCount),
        .entryActive (entryActive)
    );

    always #5 clk = ~clk;

    // sampleTick: every third clk in directed phases, random in the random phase.
    initial begin
        sampleTick = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt = (tick_cnt + 1) % 3;
            sampleTick = rand_tick ? ($urandom_range(0, 2) == 0) : (tick_cnt == 0);
        end
    end

    // Behavioural model: guess state plus per-button view of accepted level and press events.
    int          m_state;
    logic [15:0] m_user;
    int          m_cnt;
    int          m_edges;
    bit          m_seen1 [2];
    bit          m_seen2 [2];
    bit          m_lvl   [2];
    bit          m_armed [2];
    bit          m_press [2];
    int          m_run   [2];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_state = 0; m_user = 16'h0; m_cnt = 0; m_edges = 0;
                for (int b = 0; b < 2; b++) begin
                    m_seen1[b] = 0; m_seen2[b] = 0; m_lvl[b] = 0;
                    m_armed[b] = 0; m_press[b] = 0; m_run[b] = 0;
                end
            end else begin
                if (!entryEnable) begin
                    m_state = 0; m_user = 16'h0; m_cnt = 0;
                end else if (m_press[1] || m_state == 0) begin
                    m_state = 1; m_user = 16'h0; m_cnt = 0;
                end else if (m_state == 1 && m_press[0]) begin
                    m_user = {m_user[11:0], sw};
                    m_cnt++;
                    if (m_cnt == 4) m_state = 2;
                end
                for (int b = 0; b < 2; b++) begin
                    bit s, np, was_armed, now_raw;
                    s = m_seen2[b];
                    np = 0;
                    was_armed = m_armed[b];
                    now_raw = (b == 0) ? btnEnter : btnClear;
                    if (sampleTick) begin
                        if (m_edges >= 2 && !s) m_armed[b] = 1;
                        if (s != m_lvl[b]) begin
                            m_run[b]++;
                            if (m_run[b] == T) begin
                                m_lvl[b] = ~m_lvl[b];
                                m_run[b] = 0;
                                np = m_lvl[b] && was_armed;
                            end
                        end else begin
                            m_run[b] = 0;
                        end
                    end
                    m_seen2[b] = m_seen1[b];
                    m_seen1[b] = now_raw;
                    m_press[b] = np;
                end
                if (m_edges < 10) m_edges++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                tests++;
                if (userInt !== m_user || digitCount !== 3'(m_cnt) ||
                    inputReady !== (m_state == 2) || entryActive !== (m_state == 1)) begin
                    fails++;
                    $display("FAIL model t=%0t: got user=%h cnt=%0d rdy=%b act=%b, expected user=%h cnt=%0d rdy=%b act=%b",
                             $time, userInt, digitCount, inputReady, entryActive,
                             m_user, m_cnt, (m_state == 2), (m_state == 1));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic press(input logic [1:0] which, input logic [3:0] v);
        sw = v;
        btnEnter = which[0];
        btnClear = which[1];
        repeat (24) @(negedge clk);
        btnEnter = 1'b0;
        btnClear = 1'b0;
        repeat (24) @(negedge clk);
        $display("[TB] press enter=%b clear=%b sw=%h -> user=%h cnt=%0d rdy=%b",
                 which[0], which[1], v, userInt, digitCount, inputReady);
    endtask

    initial begin
        rst = 1'b1; entryEnable = 1'b0; sw = 4'h0; btnEnter = 1'b0; btnClear = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_user", userInt, 16'h0);
        chk("reset_flags", {13'h0, inputReady, entryActive, 1'b0}, 16'h0);
        rst = 1'b0;
        entryEnable = 1'b1;
        checking = 1;
        @(negedge clk);
        chk("idle_to_entry_active", {15'h0, entryActive}, 16'h1);
        chk("entry_start_user", userInt, 16'h0);
        chk("entry_start_cnt", {13'h0, digitCount}, 16'h0);
        repeat (10) @(negedge clk);

        press(2'b01, 4'hA); press(2'b01, 4'h3); press(2'b01, 4'hF); press(2'b01, 4'h1);
        chk("four_digits_user", userInt, 16'hA3F1);
        chk("four_digits_ready", {15'h0, inputReady}, 16'h1);
        chk("four_digits_cnt", {13'h0, digitCount}, 16'h4);
        press(2'b01, 4'h7);
        chk("fifth_press_ignored", userInt, 16'hA3F1);
        chk("fifth_press_cnt", {13'h0, digitCount}, 16'h4);

        press(2'b10, 4'h0);
        chk("clear_from_done", {userInt[14:0], inputReady}, 16'h0);
        chk("clear_to_entry", {15'h0, entryActive}, 16'h1);

        sw = 4'h5;
        for (int i = 0; i < 9; i++) begin
            btnEnter = ~btnEnter;
            @(negedge clk);
        end
        repeat (24) @(negedge clk);
        btnEnter = 1'b0;
        repeat (24) @(negedge clk);
        $display("[TB] bounce -> user=%h cnt=%0d", userInt, digitCount);
        chk("bounce_one_press_cnt", {13'h0, digitCount}, 16'h1);
        chk("bounce_one_press_user", userInt, 16'h0005);

        press(2'b01, 4'h7);
        chk("two_digits_user", userInt, 16'h0057);
        press(2'b10, 4'h0);
        chk("clear_mid_user", userInt, 16'h0);
        chk("clear_mid_cnt", {13'h0, digitCount}, 16'h0);
        press(2'b01, 4'h2);
        press(2'b11, 4'h9);
        chk("clear_beats_enter_cnt", {13'h0, digitCount}, 16'h0);
        chk("clear_beats_enter_user", userInt, 16'h0);

        press(2'b01, 4'h1); press(2'b01, 4'h2); press(2'b01, 4'h3); press(2'b01, 4'h4);
        chk("done_1234", userInt, 16'h1234);
        entryEnable = 1'b0;
        @(negedge clk);
        chk("disable_user", userInt, 16'h0);
        chk("disable_flags", {13'h0, digitCount}, 16'h0);
        chk("disable_ready_active", {14'h0, inputReady, entryActive}, 16'h0);
        entryEnable = 1'b1;
        repeat (3) @(negedge clk);

        press(2'b01, 4'h1); press(2'b01, 4'h2); press(2'b01, 4'h3);
        chk("three_digits", userInt, 16'h0123);
        btnEnter = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_user", userInt, 16'h0);
        chk("async_rst_flags", {12'h0, digitCount, entryActive}, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("held_through_reset_no_press", {13'h0, digitCount}, 16'h0);
        btnEnter = 1'b0;
        repeat (24) @(negedge clk);
        press(2'b01, 4'h6);
        chk("press_after_reset", userInt, 16'h0006);

        rand_tick = 1;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            sw = 4'($urandom);
            if (r < 3) entryEnable = ~entryEnable;
            else if (r < 8 && !entryEnable) entryEnable = 1'b1;
            btnEnter = ($urandom_range(0, 2) == 0);
            btnClear = ($urandom_range(0, 9) == 0);
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        btnEnter = 1'b0; btnClear = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
